activation_loader: RTL and testbench
====================================

ACTIVATION_LOADER -- requirements
Module: activation_loader

Interface
REQ-001 Parameter NUM_WORDS, default 9: 32-bit words per activation vector (288 bits).
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum stall in LOAD before abort; used only with ACT_LOADER_TIMEOUT_EN.
REQ-003 CLK  in  1  clock; all logic on posedge.
REQ-004 RSTN  in  1  reset, synchronous, active-low.
REQ-005 i_start  in  1  single-cycle pulse that begins one vector load.
REQ-006 i_valid  in  1  upstream word valid.
REQ-007 i_data  in  32  upstream activation word.
REQ-008 o_ready  out  1  loader accepts a word this cycle.
REQ-009 i_pim_busy  in  1  PIM array cannot take a new vector.
REQ-010 o_activation_in_en  out  1  write strobe to the activation buffer.
REQ-011 o_counter  out  8  word slot index for the buffer (0 = bits 287:256).
REQ-012 o_data  out  32  word presented to the buffer.
REQ-013 o_activation_out_en  out  1  vector-release strobe to the buffer.
REQ-014 o_busy  out  1  high in any state other than IDLE.
REQ-015 o_done  out  1  single-cycle pulse when a vector is released.
REQ-016 o_timeout  out  1  single-cycle pulse when a load is aborted.

Function
REQ-017 The FSM states SHALL be IDLE, LOAD, WAIT_PIM and ISSUE.
REQ-018 IDLE: o_ready=0; i_start=1 -> LOAD with word index 0; i_start SHALL be ignored in every other state.
REQ-019 LOAD: o_ready=1; accept on i_valid&&o_ready at cycle t -> at t+1 o_activation_in_en=1, o_data=accepted word, o_counter=its index.
REQ-020 The word index SHALL increment per accept; the accept of index NUM_WORDS-1 SHALL move to WAIT_PIM, and o_ready SHALL be 0 from the next cycle.
REQ-021 o_activation_in_en SHALL be 0 in all cycles without a preceding accept; o_counter and o_data hold their last values when it is 0.
REQ-022 WAIT_PIM: o_ready=0; i_pim_busy=0 -> ISSUE; otherwise stay in WAIT_PIM indefinitely.
REQ-023 ISSUE (one cycle): o_activation_out_en=1 and o_done=1 (Moore outputs), then -> IDLE.
REQ-024 Minimum latency: last accept at t, in_en at t+1, out_en at t+2 if i_pim_busy=0 at t+1.
REQ-025 i_start arriving in the ISSUE cycle SHALL be ignored; a new load needs i_start in IDLE.
REQ-026 Index arithmetic is 8-bit unsigned; NUM_WORDS SHALL be in 1..255, and the index never exceeds NUM_WORDS-1.

Reset
REQ-027 RSTN=0 SHALL set state IDLE, index 0, stall counter 0 and every output to 0 on the next edge, aborting any load in progress without out_en.
REQ-028 The first i_start SHALL be honoured in the first cycle after RSTN returns to 1.

Configuration
REQ-029 With ACT_LOADER_TIMEOUT_EN defined, a stall counter SHALL count LOAD cycles without an accept and clear on each accept.
REQ-030 With ACT_LOADER_TIMEOUT_EN defined, the stall counter reaching TIMEOUT_CYCLES SHALL pulse o_timeout for one cycle and move to IDLE with no out_en.
REQ-031 Without ACT_LOADER_TIMEOUT_EN, LOAD SHALL wait indefinitely, o_timeout SHALL be tied to 0, and no stall counter is built.

Structure
REQ-032 The shared package pim_pkg SHALL hold the state encoding (2-bit), the NUM_WORDS default, the 288-bit vector width and the 32-bit word width.
REQ-033 The block is one flat module, with no sub-module; the stall counter stays inline.

Verification
REQ-034 Reset, i_start, then 9 back-to-back words 0x11111111..0x99999999 with i_pim_busy=0 -> in_en with counter 0..8 on 9 consecutive cycles, and out_en plus done two cycles after the last accept.
REQ-035 i_valid gapped (every other cycle) -> in_en only after accepts, o_counter holds between accepts, exactly 9 strobes.
REQ-036 i_pim_busy=1 for 20 cycles after the 9th word -> out_en=0 and o_ready=0 throughout; out_en one cycle after busy drops.
REQ-037 RSTN=0 after word 4 -> all outputs 0; a new load then starts at counter 0 and completes normally.
REQ-038 i_start pulsed during LOAD and during ISSUE -> ignored; the counter sequence is unaffected.
REQ-039 With ACT_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stop i_valid after word 3 -> o_timeout pulses once, state returns to IDLE, out_en is never asserted.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared PIM definitions: loader state encoding, vector/word geometry and a
// parameter sanity helper used by activation_loader.
package pim_pkg;

  localparam int PIM_WORD_W    = 32;
  localparam int PIM_VEC_W     = 288;
  localparam int PIM_NUM_WORDS = PIM_VEC_W / PIM_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_PIM = 2'd2,
    ST_ISSUE    = 2'd3
  } loader_state_t;

  // Word index is 8-bit, so a vector holds 1..255 words; the stall limit must be nonzero.
  function automatic bit loader_cfg_ok(input int num_words, input int timeout_cycles);
    return (num_words >= 1) && (num_words <= 255) && (timeout_cycles >= 1);
  endfunction

endpackage

// File: rtl/activation_loader.sv
// Streams NUM_WORDS activation words into the PIM activation buffer and releases
// the vector once the array is free. Optional LOAD stall abort: ACT_LOADER_TIMEOUT_EN.
module activation_loader
  import pim_pkg::*;
#(
  parameter int NUM_WORDS      = PIM_NUM_WORDS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [PIM_WORD_W-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_pim_busy,
  output logic                  o_activation_in_en,
  output logic [7:0]            o_counter,
  output logic [PIM_WORD_W-1:0] o_data,
  output logic                  o_activation_out_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam bit         CFG_OK   = loader_cfg_ok(NUM_WORDS, TIMEOUT_CYCLES);
  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("activation_loader: NUM_WORDS must be 1..255 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  loader_state_t         state_reg;
  logic [7:0]            idx_reg;
  logic                  ready_reg;
  logic                  in_en_reg;
  logic [7:0]            counter_reg;
  logic [PIM_WORD_W-1:0] data_reg;
  logic                  out_en_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  accept;

  assign accept = i_valid && ready_reg;

`ifdef ACT_LOADER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_reg;
  logic               timeout_reg;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      ready_reg   <= 1'b0;
      in_en_reg   <= 1'b0;
      counter_reg <= '0;
      data_reg    <= '0;
      out_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef ACT_LOADER_TIMEOUT_EN
      stall_reg   <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      in_en_reg  <= 1'b0;
      out_en_reg <= 1'b0;
      done_reg   <= 1'b0;
`ifdef ACT_LOADER_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            state_reg <= ST_LOAD;
            idx_reg   <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b1;
`ifdef ACT_LOADER_TIMEOUT_EN
            stall_reg <= '0;
`endif
          end
        end

        ST_LOAD: begin
          if (accept) begin
            in_en_reg   <= 1'b1;
            counter_reg <= idx_reg;
            data_reg    <= i_data;
`ifdef ACT_LOADER_TIMEOUT_EN
            stall_reg   <= '0;
`endif
            // The index parks on the last slot rather than wrapping past NUM_WORDS-1.
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_WAIT_PIM;
              ready_reg <= 1'b0;
            end else begin
              idx_reg <= idx_reg + 8'd1;
            end
          end
`ifdef ACT_LOADER_TIMEOUT_EN
          else if (stall_reg == STALL_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            stall_reg   <= '0;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
`endif
        end

        ST_WAIT_PIM: begin
          // Strobes are raised on entry so they are valid for the whole ISSUE cycle.
          if (!i_pim_busy) begin
            state_reg  <= ST_ISSUE;
            out_en_reg <= 1'b1;
            done_reg   <= 1'b1;
          end
        end

        ST_ISSUE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready             = ready_reg;
  assign o_activation_in_en  = in_en_reg;
  assign o_counter           = counter_reg;
  assign o_data              = data_reg;
  assign o_activation_out_en = out_en_reg;
  assign o_busy              = busy_reg;
  assign o_done              = done_reg;
`ifdef ACT_LOADER_TIMEOUT_EN
  assign o_timeout           = timeout_reg;
`else
  assign o_timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_activation_loader.sv
// Directed bench for activation_loader: back-to-back, gapped, PIM-busy, reset
// abort, ignored i_start and (with ACT_LOADER_TIMEOUT_EN) the stall timeout.
module tb_activation_loader;

  localparam int NW = 9;
`ifdef ACT_LOADER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_pim_busy = 1'b0;
  logic        o_ready;
  logic        o_activation_in_en;
  logic [7:0]  o_counter;
  logic [31:0] o_data;
  logic        o_activation_out_en;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  activation_loader #(.NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK                 (CLK),
    .RSTN                (RSTN),
    .i_start             (i_start),
    .i_valid             (i_valid),
    .i_data              (i_data),
    .o_ready             (o_ready),
    .i_pim_busy          (i_pim_busy),
    .o_activation_in_en  (o_activation_in_en),
    .o_counter           (o_counter),
    .o_data              (o_data),
    .o_activation_out_en (o_activation_out_en),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_timeout           (o_timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] word(input int k);
    return 32'(32'h11111111 * (k + 1));
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},   o_ready, 0);
    check_eq({tag, "_in_en"},   o_activation_in_en, 0);
    check_eq({tag, "_counter"}, o_counter, 0);
    check_eq({tag, "_data"},    o_data, 0);
    check_eq({tag, "_out_en"},  o_activation_out_en, 0);
    check_eq({tag, "_busy"},    o_busy, 0);
    check_eq({tag, "_done"},    o_done, 0);
    check_eq({tag, "_timeout"}, o_timeout, 0);
  endtask

  // Issues i_start in IDLE and streams words; abort_after >= 0 returns still in LOAD.
  task automatic run_load(input string tag, input bit gapped, input int busy_hold,
                          input bit poke_start, input int abort_after);
    int  k;
    int  strobes;
    int  iter;
    int  exp_words;
    bit  drv;
    i_pim_busy = (busy_hold > 0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_eq({tag, "_ready_on_start"}, o_ready, 1);
    check_eq({tag, "_busy_on_start"},  o_busy, 1);
    k = 0; strobes = 0; iter = 0;
    while (k < NW && k != abort_after && iter < 40) begin
      drv     = !gapped || (iter % 2 == 0);
      i_valid = drv;
      i_data  = drv ? word(k) : 32'hDEADBEEF;
      i_start = poke_start && (k == 4);
      step();
      i_start = 1'b0;
      if (drv) begin
        check_eq($sformatf("%s_in_en_w%0d", tag, k),   o_activation_in_en, 1);
        check_eq($sformatf("%s_counter_w%0d", tag, k), o_counter, k);
        check_eq($sformatf("%s_data_w%0d", tag, k),    o_data, word(k));
        strobes++;
        k++;
      end else begin
        check_eq($sformatf("%s_gap_in_en_%0d", tag, iter),   o_activation_in_en, 0);
        check_eq($sformatf("%s_gap_counter_%0d", tag, iter), o_counter, k - 1);
        check_eq($sformatf("%s_gap_data_%0d", tag, iter),    o_data, word(k - 1));
      end
      check_eq($sformatf("%s_load_out_en_%0d", tag, iter), o_activation_out_en, 0);
      iter++;
    end
    i_valid = 1'b0;
    i_data  = 32'h0;
    exp_words = (abort_after >= 0) ? abort_after : NW;
    check_eq({tag, "_words_accepted"}, k, exp_words);
    if (abort_after >= 0) return;
    check_eq({tag, "_strobes"}, strobes, NW);
    check_eq({tag, "_ready_after_last"}, o_ready, 0);
    for (int c = 0; c < busy_hold; c++) begin
      step();
      check_eq($sformatf("%s_hold_out_en_%0d", tag, c), o_activation_out_en, 0);
      check_eq($sformatf("%s_hold_ready_%0d", tag, c),  o_ready, 0);
      check_eq($sformatf("%s_hold_in_en_%0d", tag, c),  o_activation_in_en, 0);
    end
    i_pim_busy = 1'b0;
    step();
    check_eq({tag, "_issue_out_en"}, o_activation_out_en, 1);
    check_eq({tag, "_issue_done"},   o_done, 1);
    check_eq({tag, "_issue_busy"},   o_busy, 1);
    check_eq({tag, "_issue_in_en"},  o_activation_in_en, 0);
    i_start = poke_start;
    step();
    i_start = 1'b0;
    check_eq({tag, "_idle_out_en"}, o_activation_out_en, 0);
    check_eq({tag, "_idle_done"},   o_done, 0);
    check_eq({tag, "_idle_busy"},   o_busy, 0);
    step();
    check_eq({tag, "_idle2_busy"},  o_busy, 0);
    check_eq({tag, "_idle2_ready"}, o_ready, 0);
  endtask

  initial begin
    repeat (3) step();
    check_all_zero("reset");

    // Start is raised in the very first cycle after reset release.
    RSTN = 1'b1;
    run_load("b2b", 1'b0, 0, 1'b0, -1);
    run_load("gap", 1'b1, 0, 1'b0, -1);
    run_load("pimbusy", 1'b0, 20, 1'b0, -1);

    run_load("rst", 1'b0, 0, 1'b0, 4);
    RSTN = 1'b0;
    step();
    check_all_zero("midload_reset");
    step();
    check_eq("midload_reset_no_out_en", o_activation_out_en, 0);
    RSTN = 1'b1;
    run_load("after_rst", 1'b0, 0, 1'b0, -1);

    run_load("start_poke", 1'b0, 0, 1'b1, -1);

`ifdef ACT_LOADER_TIMEOUT_EN
    begin
      int to_pulses;
      int to_at;
      int out_seen;
      to_pulses = 0; to_at = -1; out_seen = 0;
      run_load("to", 1'b0, 0, 1'b0, 3);
      for (int c = 1; c <= 40; c++) begin
        step();
        if (o_timeout) begin
          to_pulses++;
          if (to_at < 0) to_at = c;
        end
        if (o_activation_out_en) out_seen++;
      end
      check_eq("to_pulses",   to_pulses, 1);
      check_eq("to_cycle",    to_at, TO);
      check_eq("to_out_en",   out_seen, 0);
      check_eq("to_busy",     o_busy, 0);
      check_eq("to_ready",    o_ready, 0);
      run_load("after_to", 1'b0, 0, 1'b0, -1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
